norm8_seq: RTL and testbench

Iterative left-normalizer that sits directly downstream of the 8-bit leading-zero detector. It accepts an unsigned operand over a valid/ready handshake and latches the operand's leading-zero count from an internal LZD instance. It then shifts the operand left one bit per cycle until the MSB is set, and presents the normalized mantissa, the base-2 exponent and a zero flag over a second valid/ready handshake. It is the front end of the team's integer-to-mini-float path.

---
 rtl/norm_pkg.sv | 13 +
 rtl/lzd_n.sv | 21 ++
 rtl/norm8_seq.sv | 98 +++++++++
 tb/tb_norm8_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and constants for the integer-to-mini-float normalizer front end.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

  localparam int NORM_W  = 8;
  localparam int NORM_EW = 3;

endpackage

// File: rtl/lzd_n.sv
// Combinational W-bit leading-zero counter; returns W for an all-zero input.
module lzd_n #(
  parameter int W = 8
) (
  input  logic [W-1:0]         in_data,
  output logic [$clog2(W):0]   lz
);

  localparam int CW = $clog2(W) + 1;

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    lz = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (in_data[i]) begin
        lz = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/norm8_seq.sv
// Iterative left-normalizer: accepts an operand, shifts one bit per cycle until
// the MSB is set, then presents mantissa, exponent and zero flag.
module norm8_seq
  import norm_pkg::*;
#(
  parameter int W  = NORM_W,
  parameter int EW = NORM_EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_zero,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = $clog2(W) + 1;

  norm_state_t   state_q, state_d;
  logic [W-1:0]  mant_q, mant_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic [CW-1:0] lz;

  lzd_n #(.W(W)) u_lzd (
    .in_data (in_data),
    .lz      (lz)
  );

  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d = in_data;
          cnt_d  = lz;
          exp_d  = EW'(CW'(W - 1) - lz);
          if (in_data == '0) begin
            zero_d  = 1'b1;
            mant_d  = '0;
            exp_d   = '0;
            state_d = DONE;
          end else if (lz == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_d = {mant_q[W-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          zero_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_mant  = mant_q;
  assign out_exp   = exp_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_norm8_seq.sv
// Directed bench for norm8_seq: hand-computed mantissa/exponent/latency vectors.
module tb_norm8_seq;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_mant;
  logic [2:0] out_exp;
  logic       out_zero;
  logic       out_valid;
  logic       out_ready;

  int unsigned total;
  int unsigned bad;

  norm8_seq #(.W(8), .EW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand (out_ready held low), check latency in edges counted
  // from the accepting edge inclusive, the result, then release it.
  task automatic run_op(input logic [7:0] data, input logic [7:0] e_mant,
                        input logic [2:0] e_exp, input logic e_zero, input int e_lat);
    int lat;
    lat = 0;
    while (!in_ready && lat < 20) begin
      tick();
      lat++;
    end
    check("in_ready_before", 32'(in_ready), 32'd1);
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = 8'hA5;
    lat = 1;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_mant", 32'(out_mant), 32'(e_mant));
    check("out_exp", 32'(out_exp), 32'(e_exp));
    check("out_zero", 32'(out_zero), 32'(e_zero));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_zero_cleared", 32'(out_zero), 32'd0);
  endtask

  logic [7:0] v_data [8];
  logic [7:0] v_mant [8];
  logic [2:0] v_exp  [8];
  logic       v_zero [8];
  int         v_lat  [8];

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    v_data[0] = 8'h80; v_mant[0] = 8'h80; v_exp[0] = 3'd7; v_zero[0] = 1'b0; v_lat[0] = 1;
    v_data[1] = 8'h13; v_mant[1] = 8'h98; v_exp[1] = 3'd4; v_zero[1] = 1'b0; v_lat[1] = 4;
    v_data[2] = 8'h01; v_mant[2] = 8'h80; v_exp[2] = 3'd0; v_zero[2] = 1'b0; v_lat[2] = 8;
    v_data[3] = 8'h00; v_mant[3] = 8'h00; v_exp[3] = 3'd0; v_zero[3] = 1'b1; v_lat[3] = 1;
    v_data[4] = 8'h7F; v_mant[4] = 8'hFE; v_exp[4] = 3'd6; v_zero[4] = 1'b0; v_lat[4] = 2;
    v_data[5] = 8'h2A; v_mant[5] = 8'hA8; v_exp[5] = 3'd5; v_zero[5] = 1'b0; v_lat[5] = 3;
    v_data[6] = 8'hFF; v_mant[6] = 8'hFF; v_exp[6] = 3'd7; v_zero[6] = 1'b0; v_lat[6] = 1;
    v_data[7] = 8'h05; v_mant[7] = 8'hA0; v_exp[7] = 3'd2; v_zero[7] = 1'b0; v_lat[7] = 6;

    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_mant", 32'(out_mant), 32'd0);
    check("rst_out_exp", 32'(out_exp), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(v_data[i], v_mant[i], v_exp[i], v_zero[i], v_lat[i]);
    end

    // Backpressure with in_valid held high throughout
    in_data  = 8'h13;
    in_valid = 1'b1;
    tick();
    in_data = 8'h40;
    begin
      int n;
      n = 1;
      while (!out_valid && n < 20) begin
        check("bp_in_ready_shift", 32'(in_ready), 32'd0);
        tick();
        n++;
      end
      check("bp_latency", 32'(n), 32'd4);
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready_hold", 32'(in_ready), 32'd0);
      check("bp_mant_hold", 32'(out_mant), 32'h98);
      check("bp_exp_hold", 32'(out_exp), 32'd4);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_in_ready", 32'(in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    tick();
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_mant", 32'(out_mant), 32'h80);
    check("bp_next_exp", 32'(out_exp), 32'd6);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of shifting 0x01
    in_data  = 8'h01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_shift_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_out_mant", 32'(out_mant), 32'd0);
    check("mrst_out_exp", 32'(out_exp), 32'd0);
    check("mrst_out_zero", 32'(out_zero), 32'd0);
    for (int c = 0; c < 8; c++) begin
      check("mrst_no_valid", 32'(out_valid), 32'd0);
      tick();
    end

    run_op(8'h13, 8'h98, 3'd4, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
